// File: rtl/axi_xbar_pkg.sv
// Shared constants for the AXI crossbar.
// The crossbar blocks and its default (decode-error) slaves import these
// widths and response codes.
package axi_xbar_pkg;

    localparam int ID_W        = 4;  // AXI ID width, matching the outstanding-write table
    localparam int LEN_W       = 8;  // AWLEN / ARLEN width
    localparam int OUTSTANDING = 3;  // accepted-but-unanswered bursts (table depth)
    localparam int SLV_ID_W    = 2;  // slave-select width in the address decoder

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_id_fifo.sv
// Circular FIFO of {id, len} request descriptors for the default slaves.
// The depth does not have to be a power of two; both pointers wrap explicitly.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pointers and count only)
//   push, push_data  write an entry (ignored when full)
//   pop              drop the head entry (ignored when empty)
//   head_data        entry at the read pointer
//   peek_idx         arbitrary slot index
//   peek_data        entry stored at peek_idx
//   full, empty      occupancy flags
//   count            number of entries held (0..DEPTH)
module axi_id_fifo
    import axi_xbar_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 12,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    input  logic [PTR_W-1:0] peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign peek_data = mem[peek_idx];

    // Storage carries payload only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_decerr_wslave.sv
// Default write slave of the AXI crossbar. It accepts AWs that decode to no
// real slave, drains and discards their W beats, and answers each burst
// with DECERR under its AWID, in AW acceptance order.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   awvalid/awready/awid/awlen  AW channel (awready low while OUTSTANDING bursts are held)
//   wvalid/wready/wlast         W channel (data is dropped, so no data port)
//   bvalid/bready/bid/bresp     B channel (bresp is always DECERR)
//   prot_err                    1-cycle pulse after a beat where wlast and the awlen count disagree
module axi_decerr_wslave
    import axi_xbar_pkg::*;
#(
    parameter int ID_W        = axi_xbar_pkg::ID_W,
    parameter int LEN_W       = axi_xbar_pkg::LEN_W,
    parameter int OUTSTANDING = axi_xbar_pkg::OUTSTANDING
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             awvalid,
    output logic             awready,
    input  logic [ID_W-1:0]  awid,
    input  logic [LEN_W-1:0] awlen,
    input  logic             wvalid,
    output logic             wready,
    input  logic             wlast,
    output logic             bvalid,
    input  logic             bready,
    output logic [ID_W-1:0]  bid,
    output logic [1:0]       bresp,
    output logic             prot_err
);

    localparam int ENT_W = ID_W + LEN_W;
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);

    logic             ready_en;
    logic [CNT_W-1:0] aw_cnt;
    logic [CNT_W-1:0] wdone_cnt;
    logic [PTR_W-1:0] w_ptr;
    logic [LEN_W-1:0] beat_cnt;
    logic [ENT_W-1:0] head_entry;
    logic [ENT_W-1:0] wptr_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LEN_W-1:0] cur_len;
    logic             len_hit;
    logic             aw_fire;
    logic             w_fire;
    logic             b_fire;
    logic             burst_end;

    axi_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (aw_fire),
        .push_data ({awid, awlen}),
        .pop       (b_fire),
        .head_data (head_entry),
        .peek_idx  (w_ptr),
        .peek_data (wptr_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (aw_cnt)
    );

    // ready_en keeps both ready outputs low while in reset; it rises on the
    // first clock edge after rst_n is released.
    assign awready = ready_en && !fifo_full;
    assign wready  = ready_en && (wdone_cnt < aw_cnt);
    assign bvalid  = (wdone_cnt != '0);
    // The head slot is not reset, so bid is forced to 0 while nothing is owed.
    assign bid     = bvalid ? head_entry[ENT_W-1:LEN_W] : '0;
    assign bresp   = RESP_DECERR;

    assign aw_fire   = awvalid && awready;
    assign w_fire    = wvalid && wready;
    assign b_fire    = bvalid && bready;
    assign cur_len   = wptr_entry[LEN_W-1:0];
    assign len_hit   = (beat_cnt == cur_len);
    // Either an early wlast or a missing wlast closes the burst; prot_err flags the disagreement.
    assign burst_end = w_fire && (wlast || len_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            w_ptr     <= '0;
            beat_cnt  <= '0;
            wdone_cnt <= '0;
            prot_err  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            prot_err <= w_fire && (wlast != len_hit);
            if (burst_end) begin
                beat_cnt <= '0;
                w_ptr    <= (w_ptr == LAST_PTR) ? '0 : w_ptr + 1'b1;
            end else if (w_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            case ({burst_end, b_fire})
                2'b10:   wdone_cnt <= wdone_cnt + 1'b1;
                2'b01:   wdone_cnt <= wdone_cnt - 1'b1;
                default: wdone_cnt <= wdone_cnt;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = fifo_empty;

endmodule

// File: tb/tb_axi_decerr_wslave.sv
module tb_axi_decerr_wslave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       awvalid, wvalid, wlast, bready;
    logic [3:0] awid;
    logic [7:0] awlen;
    logic       awready, wready, bvalid, prot_err;
    logic [3:0] bid;
    logic [1:0] bresp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_decerr_wslave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .awvalid  (awvalid),
        .awready  (awready),
        .awid     (awid),
        .awlen    (awlen),
        .wvalid   (wvalid),
        .wready   (wready),
        .wlast    (wlast),
        .bvalid   (bvalid),
        .bready   (bready),
        .bid      (bid),
        .bresp    (bresp),
        .prot_err (prot_err)
    );

    typedef struct {
        logic       awv;
        logic [3:0] id;
        logic [7:0] len;
        logic       wv;
        logic       wl;
        logic       br;
        logic       e_awr;
        logic       e_wr;
        logic       e_bv;
        logic [3:0] e_bid;
        logic       e_pe;
    } vec_t;

    typedef struct {
        logic [3:0] id;
        logic [7:0] len;
    } ent_t;

    function automatic vec_t mk(logic awv, logic [3:0] id, logic [7:0] len,
                                logic wv, logic wl, logic br,
                                logic awr, logic wr, logic bv, logic [3:0] ebid, logic pe);
        vec_t v;
        v.awv = awv; v.id = id; v.len = len; v.wv = wv; v.wl = wl; v.br = br;
        v.e_awr = awr; v.e_wr = wr; v.e_bv = bv; v.e_bid = ebid; v.e_pe = pe;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, logic awr, logic wr, logic bv, logic [3:0] ebid, logic pe);
        chk({tag, ".awready"},  32'(awready),  32'(awr));
        chk({tag, ".wready"},   32'(wready),   32'(wr));
        chk({tag, ".bvalid"},   32'(bvalid),   32'(bv));
        chk({tag, ".bid"},      32'(bid),      32'(ebid));
        chk({tag, ".bresp"},    32'(bresp),    32'(2'b11));
        chk({tag, ".prot_err"}, 32'(prot_err), 32'(pe));
    endtask

    task automatic drive(logic awv, logic [3:0] id, logic [7:0] len, logic wv, logic wl, logic br);
        awvalid = awv; awid = id; awlen = len; wvalid = wv; wlast = wl; bready = br;
    endtask

    // Start of each cycle: drive on the falling edge, sample 1 time unit later.
    task automatic cyc(logic awv, logic [3:0] id, logic [7:0] len, logic wv, logic wl, logic br);
        @(negedge clk);
        drive(awv, id, len, wv, wl, br);
        #1;
    endtask

    vec_t tbl[27];
    ent_t aw_q[$];
    logic [3:0] b_q[$];

    initial begin
        int   beat;
        logic exp_pe;

        // single burst, then a 4-beat burst, then an early wlast
        tbl[0]  = mk(1'b1, 4'h5, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[1]  = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[2]  = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 4'h5, 1'b0);
        tbl[3]  = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[4]  = mk(1'b1, 4'h9, 8'd3, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[5]  = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[6]  = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[7]  = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[8]  = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[9]  = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 4'h9, 1'b0);
        tbl[10] = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[11] = mk(1'b1, 4'hA, 8'd3, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[12] = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[13] = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[14] = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 4'hA, 1'b1);
        tbl[15] = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        // fill to 3, ordering, W-end coinciding with B pop, pointer wrap
        tbl[16] = mk(1'b1, 4'h1, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[17] = mk(1'b1, 4'h2, 8'd1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[18] = mk(1'b1, 4'h3, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[19] = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[20] = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        tbl[21] = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 4'h1, 1'b0);
        tbl[22] = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b1, 1'b1, 4'h1, 1'b0);
        tbl[23] = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 4'h2, 1'b0);
        tbl[24] = mk(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 4'h2, 1'b0);
        tbl[25] = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 4'h3, 1'b0);
        tbl[26] = mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0);

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset.awready", 32'(awready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 27; i++) begin
            cyc(tbl[i].awv, tbl[i].id, tbl[i].len, tbl[i].wv, tbl[i].wl, tbl[i].br);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_awr, tbl[i].e_wr, tbl[i].e_bv,
                     tbl[i].e_bid, tbl[i].e_pe);
        end

        // B back-pressure: response held stable, then popped in one cycle
        cyc(1'b1, 4'h7, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("bp.awready", 32'(awready), 32'd1);
        cyc(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("bp.wready", 32'(wready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("bp.hold%0d.bvalid", i), 32'(bvalid), 32'd1);
            chk($sformatf("bp.hold%0d.bid", i), 32'(bid), 32'h7);
        end
        cyc(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("bp.fire.bvalid", 32'(bvalid), 32'd1);
        cyc(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("bp.after.bvalid", 32'(bvalid), 32'd0);

        // Reset in the middle of a 4-beat burst
        cyc(1'b1, 4'h4, 8'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("rmb.wready", 32'(wready), 32'd1);
        cyc(1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("rmb.in_reset", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rmb.release.awready", 32'(awready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1);
            chk_outs($sformatf("rmb.idle%0d", i), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        end
        cyc(1'b1, 4'h6, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk_outs("rmb.fresh", 1'b1, 1'b0, 1'b1, 4'h6, 1'b0);
        cyc(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("rmb.done.bvalid", 32'(bvalid), 32'd0);

        // Random traffic against a queue-based model of the slave
        beat   = 0;
        exp_pe = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic       r_awv, r_wv, r_wl, r_br;
            logic [3:0] r_id;
            logic [7:0] r_len;
            logic       m_awr, m_wr, m_bv, hit;
            logic [3:0] m_bid;

            r_awv = 1'($urandom_range(0, 1));
            r_id  = 4'($urandom);
            r_len = 8'($urandom_range(0, 3));
            r_wv  = 1'($urandom_range(0, 2) != 0);
            r_br  = 1'($urandom_range(0, 2) != 0);
            hit   = (aw_q.size() > 0) && (beat == int'(aw_q[0].len));
            r_wl  = ($urandom_range(0, 9) == 0) ? !hit : hit;

            m_awr = (aw_q.size() + b_q.size()) < 3;
            m_wr  = aw_q.size() > 0;
            m_bv  = b_q.size() > 0;
            m_bid = m_bv ? b_q[0] : 4'h0;

            cyc(r_awv, r_id, r_len, r_wv, r_wl, r_br);
            chk_outs($sformatf("rnd%0d", c), m_awr, m_wr, m_bv, m_bid, exp_pe);

            exp_pe = 1'b0;
            if (m_bv && r_br) void'(b_q.pop_front());
            if (m_wr && r_wv) begin
                exp_pe = (r_wl != hit);
                if (r_wl || hit) begin
                    b_q.push_back(aw_q[0].id);
                    void'(aw_q.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            if (m_awr && r_awv) aw_q.push_back('{id: r_id, len: r_len});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
